// File: rtl/nand_seq_arbiter.sv
// nand_seq_arbiter
//   Two-requester round-robin arbiter in front of a sequential logic unit.
//   Every logic function is built from repeated passes through a single
//   16-bit NAND unit: NAND 1 pass, AND 2, OR 3, XOR 4.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   reqN_valid/ready/op/a/b (N=0,1)   request handshake, opcode, operands
//   res_valid/ready/data/id           result handshake, value, owning requester
//   busy                              high while not IDLE
//   done_count                        completed result handshakes (wrapping)
module nand_seq_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_id,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  // pass destination select
  localparam logic [1:0] DST_T1 = 2'd0;
  localparam logic [1:0] DST_T2 = 2'd1;
  localparam logic [1:0] DST_R  = 2'd2;

  logic [1:0]  state;
  logic [15:0] a_q, b_q, t1_q, t2_q, r_q;
  logic [1:0]  op_q;
  logic        id_q;
  logic [1:0]  pass_q;
  logic        last_grant;  // index granted most recently

  logic        grant0, grant1, grant_id, any_grant;
  logic [15:0] nand_x, nand_y, nand_out;
  logic [1:0]  dst;
  logic        last_pass;

  // Contention goes to the requester not granted last; reset value 1
  // makes requester 0 win the first contention.
  always_comb begin
    grant0    = req0_valid & (~req1_valid | last_grant);
    grant1    = req1_valid & (~req0_valid | ~last_grant);
    any_grant = grant0 | grant1;
    grant_id  = grant1;
  end

  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;

  // Operand routing for the current pass into the single NAND unit.
  always_comb begin
    nand_x    = a_q;
    nand_y    = b_q;
    dst       = DST_R;
    last_pass = 1'b1;
    case (op_q)
      OP_NAND: begin
        nand_x = a_q;  nand_y = b_q;  dst = DST_R;  last_pass = 1'b1;
      end
      OP_AND: begin
        if (pass_q == 2'd0) begin
          nand_x = a_q;  nand_y = b_q;  dst = DST_T1; last_pass = 1'b0;
        end else begin
          nand_x = t1_q; nand_y = t1_q; dst = DST_R;  last_pass = 1'b1;
        end
      end
      OP_OR: begin
        case (pass_q)
          2'd0: begin nand_x = a_q;  nand_y = a_q;  dst = DST_T1; last_pass = 1'b0; end
          2'd1: begin nand_x = b_q;  nand_y = b_q;  dst = DST_T2; last_pass = 1'b0; end
          default: begin nand_x = t1_q; nand_y = t2_q; dst = DST_R; last_pass = 1'b1; end
        endcase
      end
      OP_XOR: begin
        case (pass_q)
          2'd0: begin nand_x = a_q;  nand_y = b_q;  dst = DST_T1; last_pass = 1'b0; end
          2'd1: begin nand_x = a_q;  nand_y = t1_q; dst = DST_T2; last_pass = 1'b0; end
          2'd2: begin nand_x = b_q;  nand_y = t1_q; dst = DST_T1; last_pass = 1'b0; end
          default: begin nand_x = t2_q; nand_y = t1_q; dst = DST_R; last_pass = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  // the only logic operation on operand data
  assign nand_out = ~(nand_x & nand_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      r_q        <= '0;
      op_q       <= OP_NAND;
      id_q       <= 1'b0;
      pass_q     <= '0;
      last_grant <= 1'b1;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_grant) begin
            a_q        <= grant_id ? req1_a  : req0_a;
            b_q        <= grant_id ? req1_b  : req0_b;
            op_q       <= grant_id ? req1_op : req0_op;
            id_q       <= grant_id;
            last_grant <= grant_id;
            pass_q     <= '0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          case (dst)
            DST_T1:  t1_q <= nand_out;
            DST_T2:  t2_q <= nand_out;
            default: r_q  <= nand_out;
          endcase
          pass_q <= pass_q + 2'd1;
          if (last_pass) state <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            done_count <= done_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = r_q;
  assign res_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nand_seq_arbiter.sv
module tb_nand_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id, busy;
  logic [15:0] res_data;
  logic [7:0]  done_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  nand_seq_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy), .done_count(done_count)
  );

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic scramble();
    req0_a = 16'($urandom); req0_b = 16'($urandom); req0_op = 2'($urandom);
    req1_a = 16'($urandom); req1_b = 16'($urandom); req1_op = 2'($urandom);
  endtask

  // called just after the acceptance edge
  task automatic wait_result(input int lat, input logic [15:0] r, input logic id);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!res_valid && n < 8);
    chk("latency", n, lat);
    chk("res_data", res_data, r);
    chk("res_id", res_id, id);
    chk("busy_done", busy, 1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_cnt++;
    chk("res_valid_drop", res_valid, 0);
    chk("done_count", done_count, exp_cnt);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.id, v.op, v.a, v.b);
    #1;
    chk("ready_granted", v.id ? req1_ready : req0_ready, 1);
    chk("ready_other", v.id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    scramble();
    chk("accepted_busy", busy, 1);
    wait_result(v.lat, v.r, v.id);
    handshake();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    exp_cnt = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'b00, 16'h00FF, 16'h0F0F, 16'hFFF0, 1};
    vecs[1]  = '{1'b1, 2'b11, 16'h00FF, 16'h0F0F, 16'h0FF0, 4};
    vecs[2]  = '{1'b0, 2'b01, 16'h00FF, 16'h0F0F, 16'h000F, 2};
    vecs[3]  = '{1'b1, 2'b10, 16'h00FF, 16'h0F0F, 16'h0FFF, 3};
    vecs[4]  = '{1'b1, 2'b00, 16'hFFFF, 16'h0000, 16'hFFFF, 1};
    vecs[5]  = '{1'b0, 2'b01, 16'hFFFF, 16'h0000, 16'h0000, 2};
    vecs[6]  = '{1'b1, 2'b10, 16'hFFFF, 16'h0000, 16'hFFFF, 3};
    vecs[7]  = '{1'b0, 2'b11, 16'hFFFF, 16'h0000, 16'hFFFF, 4};
    vecs[8]  = '{1'b0, 2'b00, 16'h1234, 16'h5678, 16'hEDCF, 1};
    vecs[9]  = '{1'b1, 2'b01, 16'h1234, 16'h5678, 16'h1230, 2};
    vecs[10] = '{1'b0, 2'b10, 16'h1234, 16'h5678, 16'h567C, 3};
    vecs[11] = '{1'b1, 2'b11, 16'h1234, 16'h5678, 16'h444C, 4};

    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;

    // reset state, with requests asserted during reset
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    do_reset();

    // directed vectors
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // contention after reset: req0 OR vs req1 AND
    do_reset();
    drive(1'b0, 2'b10, 16'h00FF, 16'h0F0F);
    drive(1'b1, 2'b01, 16'h00FF, 16'h0F0F);
    #1;
    chk("cont1_ready0", req0_ready, 1);
    chk("cont1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("exec_ready1_low", req1_ready, 0);
    wait_result(3, 16'h0FFF, 1'b0);
    handshake();
    #1;
    chk("cont2_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    wait_result(2, 16'h000F, 1'b1);
    handshake();
    drive(1'b0, 2'b00, 16'h0000, 16'h0000);
    drive(1'b1, 2'b00, 16'h0000, 16'h0000);
    #1;
    chk("cont3_ready0", req0_ready, 1);
    chk("cont3_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(1, 16'hFFFF, 1'b0);
    handshake();

    // stalled AND result with both requesters pushing
    drive(1'b1, 2'b01, 16'h00FF, 16'h0F0F);
    tick();
    req1_valid = 1'b0;
    wait_result(2, 16'h000F, 1'b1);
    drive(1'b0, 2'b00, 16'h1111, 16'h2222);
    drive(1'b1, 2'b00, 16'h3333, 16'h4444);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", res_valid, 1);
      chk("stall_data", res_data, 16'h000F);
      chk("stall_id", res_id, 1);
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
      chk("stall_busy", busy, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    handshake();

    // reset during XOR pass 2
    drive(1'b1, 2'b11, 16'h00FF, 16'h0F0F);
    tick();
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    exp_cnt = '0;
    #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", done_count, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("postrst_no_result", res_valid, 0);
    end
    run_vec(vecs[0]);

    // counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) run_vec(vecs[8]);
    chk("wrap_done_count", done_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/nand_seq_arbiter.md
NAND_SEQ_ARBITER -- requirements
Module: nand_seq_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
REQ-006 req0_op  input  2  opcode: 00 NAND, 01 AND, 10 OR, 11 XOR.
REQ-007 req0_a, req0_b  input  16 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b: as REQ-004..007, for requester 1.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result when high together with res_valid.
REQ-011 res_data  output  16  result value.
REQ-012 res_id  output  1  requester index (0/1) owning res_data.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done_count  output  CNT_W  number of completed result handshakes, modulo 2^CNT_W.

Function
REQ-015 All logic results SHALL be produced by exactly one internal 16-bit bitwise NAND unit (nander); no other bitwise logic on operand data.
REQ-016 FSM states SHALL be IDLE, EXEC, DONE.
REQ-017 In IDLE, grant SHALL go to the sole valid requester; if both valid, grant SHALL go to the requester not granted last (round-robin pointer).
REQ-018 reqN_ready SHALL be high only in IDLE and only for the granted requester; it may depend combinationally on both valids.
REQ-019 On acceptance: latch a, b, op, id; clear 2-bit pass counter; go to EXEC; update round-robin pointer to the granted index.
REQ-020 EXEC SHALL perform one NAND pass per clock, writing to temp registers t1, t2 or the result register:
- NAND: r=N(a,b) (1 pass).
- AND: t1=N(a,b); r=N(t1,t1) (2 passes).
- OR: t1=N(a,a); t2=N(b,b); r=N(t1,t2) (3 passes).
- XOR: t1=N(a,b); t2=N(a,t1); t1=N(b,t1); r=N(t2,t1) (4 passes).
REQ-021 After the final pass, state SHALL be DONE with res_valid=1; latency from acceptance edge to res_valid high = pass count (1/2/3/4 cycles).
REQ-022 In DONE, res_valid, res_data, res_id SHALL hold stable until res_ready=1; both reqN_ready SHALL stay low.
REQ-023 On result handshake: res_valid drops next cycle, done_count increments, state returns to IDLE; next acceptance possible in the following cycle (no overlap of requests).
REQ-024 done_count SHALL wrap from 2^CNT_W-1 to 0 without flag.
REQ-025 A requester deasserting valid before acceptance SHALL simply lose arbitration; no state change.
REQ-026 Operands on request ports after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, res_valid 0, res_data 0, res_id 0, busy 0, done_count 0, temps 0, pointer set so requester 0 wins the first contention.
REQ-028 Reset mid-EXEC or mid-DONE SHALL abandon the operation; no result is emitted after release.
REQ-029 reqN_ready SHALL be 0 while rst_n is low.

Verification
REQ-030 req0 NAND a=00FF b=0F0F -> res_valid 1 cycle after accept, res_data=FFF0, res_id=0, done_count=1.
REQ-031 req1 XOR a=00FF b=0F0F -> res_valid 4 cycles after accept, res_data=0FF0, res_id=1.
REQ-032 After reset, both valid: req0 OR, req1 AND (a=00FF b=0F0F) -> req0 first, 0FFF id 0; then req1, 000F id 1; third contention grants req0.
REQ-033 AND result pending with res_ready low 5 cycles -> res_valid, res_data=000F, res_id stable; both readys low; busy=1.
REQ-034 rst_n low during XOR pass 2 -> res_valid 0, busy 0 at once; after release, new NAND request completes normally, done_count=1.
REQ-035 256 back-to-back NAND completions with CNT_W=8 -> done_count wraps to 0.
